// File: rtl/ibex_pkg.sv
// Shared LSU types and small helpers for request decode (misalign, byte enables, store data).
package ibex_pkg;

  typedef enum logic [1:0] {
    LSU_WORD = 2'b00,
    LSU_HALF = 2'b01,
    LSU_BYTE = 2'b10
  } lsu_data_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitGnt,
    StWaitRvalid,
    StMisalignErr
  } lsu_resp_state_e;

  function automatic logic lsu_misaligned(lsu_data_type_e t, logic [1:0] off);
    case (t)
      LSU_HALF: return off[0];
      LSU_BYTE: return 1'b0;
      default:  return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lsu_be(lsu_data_type_e t, logic [1:0] off);
    case (t)
      LSU_HALF: return 4'b0011 << off;
      LSU_BYTE: return 4'b0001 << off;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_wdata_rep(lsu_data_type_e t, logic [31:0] wdata);
    case (t)
      LSU_HALF: return {2{wdata[15:0]}};
      LSU_BYTE: return {4{wdata[7:0]}};
      default:  return wdata;
    endcase
  endfunction

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Shifts returned bus data down to the accessed byte lane, truncates and extends it.
module ibex_lsu_rdata_align
  import ibex_pkg::*;
(
  input  logic [31:0]    rdata_i,
  input  logic [1:0]     off_i,
  input  lsu_data_type_e type_i,
  input  logic           sign_i,
  output logic [31:0]    rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (type_i)
      LSU_BYTE: rdata_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      LSU_HALF: rdata_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default:  rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/ibex_lsu_resp_unit.sv
// Single-outstanding LSU: issues one access on the req/gnt/rvalid bus and builds the
// writeback response. Misaligned accesses are answered with an error and never issued.
module ibex_lsu_resp_unit
  import ibex_pkg::*;
#(
  parameter bit RegisterResp = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           lsu_req_i,
  input  logic           lsu_we_i,
  input  lsu_data_type_e lsu_type_i,
  input  logic           lsu_sign_ext_i,
  input  logic [31:0]    lsu_addr_i,
  input  logic [31:0]    lsu_wdata_i,
  output logic           lsu_ready_o,
  output logic           lsu_req_done_o,
  output logic           lsu_busy_o,
  output logic           data_req_o,
  input  logic           data_gnt_i,
  output logic [31:0]    data_addr_o,
  output logic           data_we_o,
  output logic [3:0]     data_be_o,
  output logic [31:0]    data_wdata_o,
  input  logic           data_rvalid_i,
  input  logic           data_err_i,
  input  logic [31:0]    data_rdata_i,
  output logic           lsu_resp_valid_o,
  output logic           lsu_resp_err_o,
  output logic           rf_we_lsu_o,
  output logic [31:0]    rf_wdata_lsu_o
);

  lsu_resp_state_e state_q, state_d;
  logic [1:0]      off_q;
  lsu_data_type_e  type_q;
  logic            sign_q, we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q, addr_q;

  logic        rvalid_ok, ready, accept, misaligned, new_bus, bus_req, req_done;
  logic [31:0] bus_addr, bus_wdata, aligned;
  logic [3:0]  bus_be;
  logic        bus_we;
  logic        resp_valid_c, resp_err_c, rf_we_c;
  logic [31:0] rf_wdata_c;
  logic        resp_valid, resp_err, rf_we;
  logic [31:0] rf_wdata;

  always_comb begin
    rvalid_ok  = (state_q == StWaitRvalid) & data_rvalid_i;
    ready      = (state_q == StIdle) | rvalid_ok;
    accept     = ready & lsu_req_i;
    misaligned = lsu_misaligned(lsu_type_i, lsu_addr_i[1:0]);
    new_bus    = accept & ~misaligned;
    bus_req    = new_bus | (state_q == StWaitGnt);
    req_done   = (accept & misaligned) | (bus_req & data_gnt_i);

    // Fresh requests drive the bus straight from the inputs; a stalled one replays the capture.
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_be    = '0;
    bus_wdata = '0;
    if (new_bus) begin
      bus_addr  = {lsu_addr_i[31:2], 2'b00};
      bus_we    = lsu_we_i;
      bus_be    = lsu_be(lsu_type_i, lsu_addr_i[1:0]);
      bus_wdata = lsu_wdata_rep(lsu_type_i, lsu_wdata_i);
    end else if (state_q == StWaitGnt) begin
      bus_addr  = addr_q;
      bus_we    = we_q;
      bus_be    = be_q;
      bus_wdata = wdata_q;
    end

    state_d = state_q;
    unique case (state_q)
      StIdle, StWaitRvalid: begin
        if (state_q == StWaitRvalid && !data_rvalid_i) begin
          state_d = StWaitRvalid;
        end else if (accept) begin
          state_d = misaligned ? StMisalignErr : (data_gnt_i ? StWaitRvalid : StWaitGnt);
        end else begin
          state_d = StIdle;
        end
      end
      StWaitGnt:     state_d = data_gnt_i ? StWaitRvalid : StWaitGnt;
      StMisalignErr: state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      off_q   <= '0;
      type_q  <= LSU_WORD;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (new_bus) begin
        off_q   <= lsu_addr_i[1:0];
        type_q  <= lsu_type_i;
        sign_q  <= lsu_sign_ext_i;
        we_q    <= lsu_we_i;
        be_q    <= bus_be;
        wdata_q <= bus_wdata;
        addr_q  <= bus_addr;
      end
    end
  end

  ibex_lsu_rdata_align u_rdata_align (
    .rdata_i (data_rdata_i),
    .off_i   (off_q),
    .type_i  (type_q),
    .sign_i  (sign_q),
    .rdata_o (aligned)
  );

  always_comb begin
    resp_valid_c = rvalid_ok | (state_q == StMisalignErr);
    resp_err_c   = (rvalid_ok & data_err_i) | (state_q == StMisalignErr);
    rf_we_c      = rvalid_ok & ~we_q & ~data_err_i;
    rf_wdata_c   = rf_we_c ? aligned : '0;
  end

  if (RegisterResp) begin : g_resp_reg
    logic        valid_q, err_q, rf_we_q;
    logic [31:0] rf_wdata_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        valid_q    <= 1'b0;
        err_q      <= 1'b0;
        rf_we_q    <= 1'b0;
        rf_wdata_q <= '0;
      end else begin
        valid_q    <= resp_valid_c;
        err_q      <= resp_err_c;
        rf_we_q    <= rf_we_c;
        rf_wdata_q <= rf_wdata_c;
      end
    end
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    assign rf_we      = rf_we_q;
    assign rf_wdata   = rf_wdata_q;
  end else begin : g_resp_comb
    assign resp_valid = resp_valid_c;
    assign resp_err   = resp_err_c;
    assign rf_we      = rf_we_c;
    assign rf_wdata   = rf_wdata_c;
  end

  // Outputs are forced quiet for as long as reset is held.
  assign lsu_ready_o      = rst_ni & ready;
  assign lsu_req_done_o   = rst_ni & req_done;
  assign lsu_busy_o       = rst_ni & (state_q != StIdle);
  assign data_req_o       = rst_ni & bus_req;
  assign data_addr_o      = rst_ni ? bus_addr : '0;
  assign data_we_o        = rst_ni & bus_we;
  assign data_be_o        = rst_ni ? bus_be : '0;
  assign data_wdata_o     = rst_ni ? bus_wdata : '0;
  assign lsu_resp_valid_o = rst_ni & resp_valid;
  assign lsu_resp_err_o   = rst_ni & resp_err;
  assign rf_we_lsu_o      = rst_ni & rf_we;
  assign rf_wdata_lsu_o   = rst_ni ? rf_wdata : '0;

  a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> state_q == StWaitRvalid);

  a_bus_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (data_req_o && !data_gnt_i) |=> ($stable(data_addr_o) && $stable(data_be_o) &&
                                     $stable(data_we_o) && $stable(data_wdata_o)));

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Directed bench for ibex_lsu_resp_unit with hand-computed expectations.
module tb_ibex_lsu_resp_unit;
  import ibex_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           lsu_req_i = 1'b0;
  logic           lsu_we_i = 1'b0;
  lsu_data_type_e lsu_type_i = LSU_WORD;
  logic           lsu_sign_ext_i = 1'b0;
  logic [31:0]    lsu_addr_i = '0;
  logic [31:0]    lsu_wdata_i = '0;
  logic           lsu_ready_o, lsu_req_done_o, lsu_busy_o;
  logic           data_req_o;
  logic           data_gnt_i = 1'b0;
  logic [31:0]    data_addr_o;
  logic           data_we_o;
  logic [3:0]     data_be_o;
  logic [31:0]    data_wdata_o;
  logic           data_rvalid_i = 1'b0;
  logic           data_err_i = 1'b0;
  logic [31:0]    data_rdata_i = '0;
  logic           lsu_resp_valid_o, lsu_resp_err_o, rf_we_lsu_o;
  logic [31:0]    rf_wdata_lsu_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  ibex_lsu_resp_unit #(.RegisterResp(1'b0)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_ready_o      (lsu_ready_o),
    .lsu_req_done_o   (lsu_req_done_o),
    .lsu_busy_o       (lsu_busy_o),
    .data_req_o       (data_req_o),
    .data_gnt_i       (data_gnt_i),
    .data_addr_o      (data_addr_o),
    .data_we_o        (data_we_o),
    .data_be_o        (data_be_o),
    .data_wdata_o     (data_wdata_o),
    .data_rvalid_i    (data_rvalid_i),
    .data_err_i       (data_err_i),
    .data_rdata_i     (data_rdata_i),
    .lsu_resp_valid_o (lsu_resp_valid_o),
    .lsu_resp_err_o   (lsu_resp_err_o),
    .rf_we_lsu_o      (rf_we_lsu_o),
    .rf_wdata_lsu_o   (rf_wdata_lsu_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Request with immediate grant, response on the following cycle, then an idle cycle.
  task automatic access(input string name, input logic we, input lsu_data_type_e t,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic err, input logic [3:0] exp_be,
                        input logic [31:0] exp_bwdata, input logic [31:0] exp_rf);
    next_cycle();
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = t; lsu_sign_ext_i = sgn;
    lsu_addr_i = addr; lsu_wdata_i = wdata; data_gnt_i = 1'b1;
    @(negedge clk_i);
    check_eq({name, ".req"}, data_req_o, 1);
    check_eq({name, ".addr"}, data_addr_o, addr & 32'hFFFF_FFFC);
    check_eq({name, ".be"}, data_be_o, exp_be);
    check_eq({name, ".we"}, data_we_o, we);
    check_eq({name, ".bwdata"}, data_wdata_o, exp_bwdata);
    check_eq({name, ".done"}, lsu_req_done_o, 1);
    next_cycle();
    lsu_req_i = 1'b0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = rdata; data_err_i = err;
    @(negedge clk_i);
    check_eq({name, ".rvalid"}, lsu_resp_valid_o, 1);
    check_eq({name, ".rerr"}, lsu_resp_err_o, err);
    check_eq({name, ".rfwe"}, rf_we_lsu_o, !we && !err);
    check_eq({name, ".rfwdata"}, rf_wdata_lsu_o, exp_rf);
    next_cycle();
    data_rvalid_i = 1'b0; data_err_i = 1'b0;
    @(negedge clk_i);
    check_eq({name, ".quiet"}, lsu_resp_valid_o, 0);
    check_eq({name, ".idle"}, lsu_busy_o, 0);
  endtask

  initial begin
    // Reset held with a pending request: everything must stay quiet.
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_1000;
    repeat (2) next_cycle();
    @(negedge clk_i);
    check_eq("rst.req", data_req_o, 0);
    check_eq("rst.ready", lsu_ready_o, 0);
    check_eq("rst.busy", lsu_busy_o, 0);
    check_eq("rst.addr", data_addr_o, 0);
    next_cycle();
    rst_ni = 1'b1; lsu_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("post.ready", lsu_ready_o, 1);
    check_eq("post.req", data_req_o, 0);
    check_eq("post.rvalid", lsu_resp_valid_o, 0);

    access("wload", 0, LSU_WORD, 0, 32'h0000_1000, 0, 32'hDEAD_BEEF, 0, 4'hF, 0,
           32'hDEAD_BEEF);
    access("sbyte", 0, LSU_BYTE, 1, 32'h0000_2003, 0, 32'h8012_3456, 0, 4'b1000, 0,
           32'hFFFF_FF80);
    access("ubyte", 0, LSU_BYTE, 0, 32'h0000_2003, 0, 32'h8012_3456, 0, 4'b1000, 0,
           32'h0000_0080);
    access("shalf", 0, LSU_HALF, 1, 32'h0000_2002, 0, 32'h8001_1234, 0, 4'b1100, 0,
           32'hFFFF_8001);
    access("uhalf", 0, LSU_HALF, 0, 32'h0000_2000, 0, 32'h1234_F00D, 0, 4'b0011, 0,
           32'h0000_F00D);
    access("sbyte1", 0, LSU_BYTE, 1, 32'h0000_2001, 0, 32'h0000_7F00, 0, 4'b0010, 0,
           32'h0000_007F);
    access("lderr", 0, LSU_WORD, 0, 32'h0000_5000, 0, 32'h1234_5678, 1, 4'hF, 0, 0);
    access("bstore", 1, LSU_BYTE, 0, 32'h0000_5001, 32'h0000_00A5, 0, 0, 4'b0010,
           32'hA5A5_A5A5, 0);

    // Half store with the grant held off for three cycles.
    next_cycle();
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_type_i = LSU_HALF;
    lsu_addr_i = 32'h0000_3002; lsu_wdata_i = 32'h0000_ABCD; data_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next_cycle();
        lsu_req_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_type_i = LSU_WORD;
        data_gnt_i = (i == 3);
      end
      @(negedge clk_i);
      check_eq($sformatf("hst%0d.req", i), data_req_o, 1);
      check_eq($sformatf("hst%0d.addr", i), data_addr_o, 32'h0000_3000);
      check_eq($sformatf("hst%0d.be", i), data_be_o, 4'b1100);
      check_eq($sformatf("hst%0d.wdata", i), data_wdata_o, 32'hABCD_ABCD);
      check_eq($sformatf("hst%0d.we", i), data_we_o, 1);
      check_eq($sformatf("hst%0d.done", i), lsu_req_done_o, i == 3);
      if (i > 0) check_eq($sformatf("hst%0d.ready", i), lsu_ready_o, 0);
    end
    next_cycle();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check_eq("hst.rvalid", lsu_resp_valid_o, 1);
    check_eq("hst.rfwe", rf_we_lsu_o, 0);
    check_eq("hst.rerr", lsu_resp_err_o, 0);
    check_eq("hst.rfwdata", rf_wdata_lsu_o, 0);
    check_eq("hst.noreq", data_req_o, 0);
    next_cycle();
    data_rvalid_i = 1'b0; lsu_we_i = 1'b0;

    // Misaligned accesses: word 0x4001, half 0x4003, word 0x4002.
    for (int m = 0; m < 3; m++) begin
      next_cycle();
      lsu_req_i = 1'b1; lsu_we_i = 1'b0;
      lsu_type_i = (m == 1) ? LSU_HALF : LSU_WORD;
      lsu_addr_i = (m == 0) ? 32'h0000_4001 : (m == 1) ? 32'h0000_4003 : 32'h0000_4002;
      @(negedge clk_i);
      check_eq($sformatf("mis%0d.req", m), data_req_o, 0);
      check_eq($sformatf("mis%0d.done", m), lsu_req_done_o, 1);
      check_eq($sformatf("mis%0d.early", m), lsu_resp_valid_o, 0);
      next_cycle();
      lsu_req_i = 1'b0;
      @(negedge clk_i);
      check_eq($sformatf("mis%0d.rvalid", m), lsu_resp_valid_o, 1);
      check_eq($sformatf("mis%0d.rerr", m), lsu_resp_err_o, 1);
      check_eq($sformatf("mis%0d.rfwe", m), rf_we_lsu_o, 0);
      check_eq($sformatf("mis%0d.req2", m), data_req_o, 0);
      check_eq($sformatf("mis%0d.ready", m), lsu_ready_o, 0);
      next_cycle();
      @(negedge clk_i);
      check_eq($sformatf("mis%0d.idle", m), lsu_busy_o, 0);
      check_eq($sformatf("mis%0d.rdy2", m), lsu_ready_o, 1);
      check_eq($sformatf("mis%0d.quiet", m), lsu_resp_valid_o, 0);
    end

    // Back-to-back: second request issued in the rvalid cycle of the first.
    next_cycle();
    lsu_req_i = 1'b1; lsu_type_i = LSU_WORD; lsu_addr_i = 32'h0000_6000; data_gnt_i = 1'b1;
    @(negedge clk_i);
    check_eq("b2b.done1", lsu_req_done_o, 1);
    next_cycle();
    lsu_type_i = LSU_BYTE; lsu_addr_i = 32'h0000_6004; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'h0BAD_F00D;
    @(negedge clk_i);
    check_eq("b2b.rvalid1", lsu_resp_valid_o, 1);
    check_eq("b2b.rfwdata1", rf_wdata_lsu_o, 32'h0BAD_F00D);
    check_eq("b2b.ready", lsu_ready_o, 1);
    check_eq("b2b.req2", data_req_o, 1);
    check_eq("b2b.addr2", data_addr_o, 32'h0000_6004);
    check_eq("b2b.be2", data_be_o, 4'b0001);
    next_cycle();
    lsu_req_i = 1'b0; data_rvalid_i = 1'b0; data_gnt_i = 1'b1;
    @(negedge clk_i);
    check_eq("b2b.gntreq", data_req_o, 1);
    check_eq("b2b.done2", lsu_req_done_o, 1);
    check_eq("b2b.norsp", lsu_resp_valid_o, 0);
    next_cycle();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b1; data_rdata_i = 32'h1234_56AB;
    @(negedge clk_i);
    check_eq("b2b.rfwdata2", rf_wdata_lsu_o, 32'h0000_00AB);
    next_cycle();
    data_rvalid_i = 1'b0;

    // Reset while waiting for rvalid; the late rvalid must be dropped.
    next_cycle();
    lsu_req_i = 1'b1; lsu_type_i = LSU_WORD; lsu_addr_i = 32'h0000_7000; data_gnt_i = 1'b1;
    @(negedge clk_i);
    check_eq("rwr.done", lsu_req_done_o, 1);
    next_cycle();
    lsu_req_i = 1'b0; data_gnt_i = 1'b0; rst_ni = 1'b0;
    next_cycle();
    data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
    @(negedge clk_i);
    check_eq("rwr.rvalid", lsu_resp_valid_o, 0);
    check_eq("rwr.rfwe", rf_we_lsu_o, 0);
    check_eq("rwr.rfwdata", rf_wdata_lsu_o, 0);
    check_eq("rwr.busy", lsu_busy_o, 0);
    check_eq("rwr.req", data_req_o, 0);
    next_cycle();
    rst_ni = 1'b1; data_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rwr.idle", lsu_busy_o, 0);
    check_eq("rwr.ready", lsu_ready_o, 1);
    check_eq("rwr.quiet", lsu_resp_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
